// File: rtl/puf_eval_scheduler.sv
// puf_eval_scheduler: round-robin share of the DD/XOR PUF controller pair between two
// requesters; launches one evaluation at a time and holds its result until acknowledged.
module puf_eval_scheduler #(
  parameter int               TMO_W   = 20,
  parameter logic [TMO_W-1:0] TMO_CYC = TMO_W'(1000000)
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         REQ_A,
  input  logic         SEL_A,
  input  logic [7:0]   CODE_A,
  input  logic [15:0]  CNT_A,
  input  logic         REQ_B,
  input  logic         SEL_B,
  input  logic [7:0]   CODE_B,
  input  logic [15:0]  CNT_B,
  output logic         GNT_A,
  output logic         GNT_B,
  output logic [7:0]   CODE_OUT,
  output logic [15:0]  CNT_VAL,
  output logic         START_DD,
  output logic         START_XOR,
  input  logic         DONE_DD,
  input  logic         DONE_XOR,
  input  logic [127:0] PUF_DD,
  input  logic [127:0] PUF_XOR,
  output logic [127:0] RESULT,
  output logic         RESULT_VALID,
  output logic         RESULT_ID,
  output logic         RESULT_TMO,
  input  logic         RESULT_ACK,
  output logic         BUSY
);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, HOLD} state_t;

  state_t             state_q, state_d;
  logic               ptr_q, ptr_d;
  logic               sel_q, sel_d;
  logic               id_q, id_d;
  logic [7:0]         code_q, code_d;
  logic [15:0]        cnt_q, cnt_d;
  logic               gnt_a_q, gnt_a_d;
  logic               gnt_b_q, gnt_b_d;
  logic               start_dd_q, start_dd_d;
  logic               start_xor_q, start_xor_d;
  logic [TMO_W-1:0]   tmo_cnt_q, tmo_cnt_d;
  logic               done_dd_q, done_dd_d;
  logic               done_xor_q, done_xor_d;
  logic [127:0]       result_q, result_d;
  logic               res_valid_q, res_valid_d;
  logic               res_id_q, res_id_d;
  logic               res_tmo_q, res_tmo_d;
  logic               win;
  logic               edge_det;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    sel_d       = sel_q;
    id_d        = id_q;
    code_d      = code_q;
    cnt_d       = cnt_q;
    gnt_a_d     = 1'b0;
    gnt_b_d     = 1'b0;
    start_dd_d  = 1'b0;
    start_xor_d = 1'b0;
    tmo_cnt_d   = tmo_cnt_q;
    done_dd_d   = done_dd_q;
    done_xor_d  = done_xor_q;
    result_d    = result_q;
    res_valid_d = res_valid_q;
    res_id_d    = res_id_q;
    res_tmo_d   = res_tmo_q;
    win         = 1'b0;
    // Only a rising edge of the selected DONE counts, so a level left over from an earlier run is ignored.
    edge_det    = sel_q ? (DONE_XOR & ~done_xor_q) : (DONE_DD & ~done_dd_q);

    case (state_q)
      IDLE: begin
        if (REQ_A || REQ_B) begin
          win         = (REQ_A && REQ_B) ? ptr_q : ~REQ_A;
          id_d        = win;
          sel_d       = win ? SEL_B : SEL_A;
          code_d      = win ? CODE_B : CODE_A;
          cnt_d       = win ? CNT_B : CNT_A;
          gnt_a_d     = ~win;
          gnt_b_d     = win;
          start_dd_d  = ~(win ? SEL_B : SEL_A);
          start_xor_d = win ? SEL_B : SEL_A;
          state_d     = LAUNCH;
        end
      end
      LAUNCH: begin
        tmo_cnt_d  = '0;
        done_dd_d  = DONE_DD;
        done_xor_d = DONE_XOR;
        state_d    = WAIT;
      end
      WAIT: begin
        done_dd_d  = DONE_DD;
        done_xor_d = DONE_XOR;
        if (tmo_cnt_q != '1) begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
        if (edge_det) begin
          result_d    = sel_q ? PUF_XOR : PUF_DD;
          res_tmo_d   = 1'b0;
          res_valid_d = 1'b1;
          res_id_d    = id_q;
          state_d     = HOLD;
        end else if (tmo_cnt_q >= TMO_CYC - 1'b1) begin
          result_d    = '0;
          res_tmo_d   = 1'b1;
          res_valid_d = 1'b1;
          res_id_d    = id_q;
          state_d     = HOLD;
        end
      end
      HOLD: begin
        if (RESULT_ACK) begin
          res_valid_d = 1'b0;
          ptr_d       = ~id_q;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q     <= IDLE;
      ptr_q       <= 1'b0;
      sel_q       <= 1'b0;
      id_q        <= 1'b0;
      code_q      <= '0;
      cnt_q       <= '0;
      gnt_a_q     <= 1'b0;
      gnt_b_q     <= 1'b0;
      start_dd_q  <= 1'b0;
      start_xor_q <= 1'b0;
      tmo_cnt_q   <= '0;
      done_dd_q   <= 1'b0;
      done_xor_q  <= 1'b0;
      result_q    <= '0;
      res_valid_q <= 1'b0;
      res_id_q    <= 1'b0;
      res_tmo_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      sel_q       <= sel_d;
      id_q        <= id_d;
      code_q      <= code_d;
      cnt_q       <= cnt_d;
      gnt_a_q     <= gnt_a_d;
      gnt_b_q     <= gnt_b_d;
      start_dd_q  <= start_dd_d;
      start_xor_q <= start_xor_d;
      tmo_cnt_q   <= tmo_cnt_d;
      done_dd_q   <= done_dd_d;
      done_xor_q  <= done_xor_d;
      result_q    <= result_d;
      res_valid_q <= res_valid_d;
      res_id_q    <= res_id_d;
      res_tmo_q   <= res_tmo_d;
    end
  end

  assign GNT_A        = gnt_a_q;
  assign GNT_B        = gnt_b_q;
  assign CODE_OUT     = code_q;
  assign CNT_VAL      = cnt_q;
  assign START_DD     = start_dd_q;
  assign START_XOR    = start_xor_q;
  assign RESULT       = result_q;
  assign RESULT_VALID = res_valid_q;
  assign RESULT_ID    = res_id_q;
  assign RESULT_TMO   = res_tmo_q;
  assign BUSY         = (state_q != IDLE);

endmodule

// File: tb/tb_puf_eval_scheduler.sv
// Self-checking bench for puf_eval_scheduler: randomized jobs against a reference model,
// with expected results queued at grant time and checked by an independent monitor.
module tb_puf_eval_scheduler;

  localparam int TMO = 16;

  logic         CLK = 1'b0;
  logic         RESET = 1'b1;
  logic         REQ_A = 1'b0, SEL_A = 1'b0, REQ_B = 1'b0, SEL_B = 1'b0;
  logic [7:0]   CODE_A = '0, CODE_B = '0;
  logic [15:0]  CNT_A = '0, CNT_B = '0;
  logic         GNT_A, GNT_B, START_DD, START_XOR;
  logic [7:0]   CODE_OUT;
  logic [15:0]  CNT_VAL;
  logic         DONE_DD = 1'b0, DONE_XOR = 1'b0;
  logic [127:0] PUF_DD = '0, PUF_XOR = '0;
  logic [127:0] RESULT;
  logic         RESULT_VALID, RESULT_ID, RESULT_TMO;
  logic         RESULT_ACK = 1'b0;
  logic         BUSY;

  typedef struct {
    logic         id;
    logic         tmo;
    logic [127:0] res;
    int           lat;
  } exp_t;

  exp_t sbq[$];
  int   nChecks = 0;
  int   nFails  = 0;
  logic modelPtr = 1'b0;

  puf_eval_scheduler #(.TMO_W(20), .TMO_CYC(20'd16)) dut (
    .CLK(CLK), .RESET(RESET),
    .REQ_A(REQ_A), .SEL_A(SEL_A), .CODE_A(CODE_A), .CNT_A(CNT_A),
    .REQ_B(REQ_B), .SEL_B(SEL_B), .CODE_B(CODE_B), .CNT_B(CNT_B),
    .GNT_A(GNT_A), .GNT_B(GNT_B), .CODE_OUT(CODE_OUT), .CNT_VAL(CNT_VAL),
    .START_DD(START_DD), .START_XOR(START_XOR),
    .DONE_DD(DONE_DD), .DONE_XOR(DONE_XOR), .PUF_DD(PUF_DD), .PUF_XOR(PUF_XOR),
    .RESULT(RESULT), .RESULT_VALID(RESULT_VALID), .RESULT_ID(RESULT_ID),
    .RESULT_TMO(RESULT_TMO), .RESULT_ACK(RESULT_ACK), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string name, input logic [159:0] act, input logic [159:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Monitor: pops one expectation per rising RESULT_VALID, latency counted from the START pulse.
  initial begin
    logic prevValid;
    int   sinceStart;
    exp_t e;
    prevValid  = 1'b0;
    sinceStart = 0;
    forever begin
      @(negedge CLK);
      if (!RESET) begin
        prevValid = 1'b0;
      end else begin
        if (START_DD || START_XOR) sinceStart = 0;
        else sinceStart++;
        if (RESULT_VALID && !prevValid) begin
          if (sbq.size() == 0) begin
            checkOutput("unexpected_result_valid", 160'(RESULT_VALID), 160'(0));
          end else begin
            e = sbq.pop_front();
            checkOutput("result_id", 160'(RESULT_ID), 160'(e.id));
            checkOutput("result_tmo", 160'(RESULT_TMO), 160'(e.tmo));
            checkOutput("result_data", 160'(RESULT), 160'(e.res));
            checkOutput("result_latency", 160'(sinceStart), 160'(e.lat));
          end
        end
        prevValid = RESULT_VALID;
      end
    end
  end

  // One job from request to acknowledge; called at a negedge, returns at a negedge with the DUT idle.
  task automatic applyStimulus(input logic ra, input logic rb, input logic sa, input logic sb,
                               input logic [7:0] ca, input logic [7:0] cb,
                               input logic [15:0] na, input logic [15:0] nb,
                               input logic [19:0] wave, input logic [127:0] puf,
                               input int ackDelay, input logic reqDuringHold);
    logic win, wsel;
    logic [7:0] wcode;
    logic [15:0] wcnt;
    int waited, k;
    logic got;
    exp_t e;
    REQ_A = ra; REQ_B = rb; SEL_A = sa; SEL_B = sb;
    CODE_A = ca; CODE_B = cb; CNT_A = na; CNT_B = nb; RESULT_ACK = 1'b0;
    win   = (ra && rb) ? modelPtr : !ra;
    wsel  = win ? sb : sa;
    wcode = win ? cb : ca;
    wcnt  = win ? nb : na;
    waited = 0;
    got    = 1'b0;
    while (!got && waited < 10) begin
      @(negedge CLK);
      waited++;
      if (GNT_A || GNT_B) got = 1'b1;
    end
    if (!got) begin
      checkOutput("grant_seen", 160'(0), 160'(1));
      REQ_A = 1'b0; REQ_B = 1'b0;
      return;
    end
    checkOutput("grant_latency", 160'(waited), 160'(1));
    checkOutput("grant_a_b", 160'({GNT_A, GNT_B}), 160'({!win, win}));
    checkOutput("start_dd_xor", 160'({START_DD, START_XOR}), 160'({!wsel, wsel}));
    checkOutput("code_cnt_out", 160'({CODE_OUT, CNT_VAL}), 160'({wcode, wcnt}));
    checkOutput("busy_launch", 160'(BUSY), 160'(1));

    k = -1;
    for (int j = 0; j < 19; j++) begin
      if (k < 0 && wave[j+1] && !wave[j]) k = j;
    end
    if (k >= 0 && k <= TMO - 1) e = '{win, 1'b0, puf, k + 2};
    else e = '{win, 1'b1, 128'd0, TMO + 1};
    sbq.push_back(e);

    for (int i = 0; i < 20; i++) begin
      if (i > 0) begin
        @(negedge CLK);
        checkOutput("no_extra_pulse", 160'({GNT_A, GNT_B, START_DD, START_XOR}), 160'(0));
      end
      if (wsel) begin
        DONE_XOR = wave[i]; PUF_XOR = puf;
        DONE_DD = 1'($urandom); PUF_DD = rand128();
      end else begin
        DONE_DD = wave[i]; PUF_DD = puf;
        DONE_XOR = 1'($urandom); PUF_XOR = rand128();
      end
      REQ_A = 1'($urandom); REQ_B = 1'($urandom);
      SEL_A = 1'($urandom); SEL_B = 1'($urandom);
      CODE_A = 8'($urandom); CODE_B = 8'($urandom);
      CNT_A = 16'($urandom); CNT_B = 16'($urandom);
      RESULT_ACK = (i < e.lat - 1) ? 1'($urandom) : 1'b0;
    end
    REQ_A = 1'b0;
    REQ_B = reqDuringHold;
    checkOutput("valid_by_deadline", 160'(RESULT_VALID), 160'(1));
    checkOutput("code_cnt_held", 160'({CODE_OUT, CNT_VAL}), 160'({wcode, wcnt}));

    for (int d = 0; d < ackDelay; d++) begin
      @(negedge CLK);
      checkOutput("hold_stable",
                  160'({RESULT_VALID, RESULT_ID, RESULT_TMO, GNT_A, GNT_B, START_DD, START_XOR, BUSY, RESULT}),
                  160'({1'b1, win, e.tmo, 4'b0000, 1'b1, e.res}));
    end
    @(negedge CLK);
    RESULT_ACK = 1'b1;
    @(negedge CLK);
    RESULT_ACK = 1'b0;
    modelPtr = !win;
    checkOutput("after_ack", 160'({RESULT_VALID, BUSY, RESULT}), 160'({2'b00, e.res}));
  endtask

  // Aborts a job with an asynchronous reset part-way through WAIT.
  task automatic resetMidWait(input int waitCycles);
    int waited;
    logic got;
    REQ_A = 1'b1; REQ_B = 1'b1; SEL_A = 1'($urandom); SEL_B = 1'($urandom);
    CODE_A = 8'($urandom); CODE_B = 8'($urandom);
    DONE_DD = 1'b0; DONE_XOR = 1'b0;
    waited = 0;
    got = 1'b0;
    while (!got && waited < 10) begin
      @(negedge CLK);
      waited++;
      if (GNT_A || GNT_B) got = 1'b1;
    end
    checkOutput("reset_job_grant", 160'(got), 160'(1));
    repeat (waitCycles) @(negedge CLK);
    #2 RESET = 1'b0;
    #1;
    checkOutput("async_reset_outputs",
                160'({GNT_A, GNT_B, START_DD, START_XOR, RESULT_VALID, RESULT_ID, RESULT_TMO, BUSY, CODE_OUT, CNT_VAL}),
                160'(0));
    checkOutput("async_reset_result", 160'(RESULT), 160'(0));
    REQ_A = 1'b0; REQ_B = 1'b0;
    repeat (3) @(negedge CLK);
    checkOutput("reset_held_busy", 160'({BUSY, RESULT_VALID}), 160'(0));
    #2 RESET = 1'b1;
    modelPtr = 1'b0;
    @(negedge CLK);
  endtask

  initial begin
    logic ra, rb;
    logic [19:0] wv;
    int mode, kk;
    #1 RESET = 1'b0;
    #1;
    checkOutput("reset_outputs",
                160'({GNT_A, GNT_B, START_DD, START_XOR, RESULT_VALID, RESULT_ID, RESULT_TMO, BUSY, CODE_OUT, CNT_VAL}),
                160'(0));
    checkOutput("reset_result", 160'(RESULT), 160'(0));
    repeat (2) @(negedge CLK);
    #2 RESET = 1'b1;
    @(negedge CLK);

    $display("[TB] single requester A, DD");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h3C, 8'h00, 16'h0100, 16'h0000,
                  20'hFFC00, {16{8'hA5}}, 3, 1'b0);

    $display("[TB] stale DONE_DD level then fresh edge");
    DONE_DD = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h11, 8'h00, 16'h0022, 16'h0000,
                  20'hFFF8F, rand128(), 1, 1'b0);

    $display("[TB] ACK withheld with REQ_B pending");
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 8'h5A, 8'h00, 16'h1234, 16'h0000,
                  20'hFFFF0, rand128(), 50, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h77, 16'h0000, 16'h4321,
                  20'hFFFE0, rand128(), 0, 1'b0);

    $display("[TB] async reset mid-WAIT");
    resetMidWait(5);

    $display("[TB] both requesting, four jobs");
    for (int j = 0; j < 4; j++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 8'($urandom), 8'($urandom), 16'($urandom), 16'($urandom),
                    20'hFFFFF << (3 + j), rand128(), j, 1'b0);
    end

    $display("[TB] timeout on XOR");
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 8'h42, 8'h00, 16'h0042, 16'h0000,
                  20'h00000, rand128(), 2, 1'b0);

    $display("[TB] randomized jobs");
    for (int n = 0; n < 40; n++) begin
      ra = 1'($urandom);
      rb = 1'($urandom);
      if (!ra && !rb) ra = 1'b1;
      mode = int'($urandom_range(0, 5));
      kk = int'($urandom_range(0, 18));
      case (mode)
        0, 1, 2: wv = 20'hFFFFF << (kk + 1);
        3:       wv = 20'h00000;
        4:       wv = 20'hFFFFF;
        default: wv = 20'($urandom);
      endcase
      applyStimulus(ra, rb, 1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom),
                    16'($urandom), 16'($urandom), wv, rand128(),
                    int'($urandom_range(0, 4)), 1'b0);
    end

    repeat (3) @(negedge CLK);
    checkOutput("scoreboard_empty", 160'(sbq.size()), 160'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
